// File: rtl/sign_minmax_unit.sv
// rtl/sign_minmax_unit.sv - IEEE sign-injection and min/max unit with a 2-entry output FIFO
module sign_minmax_unit #(
    parameter int FLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    output logic            ready_out,
    output logic            valid_out,
    input  logic            ready_in,
    input  logic [4:0]      op,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic [FLEN-1:0] float_out,
    output logic            invalid
);

    localparam int EXP_W = (FLEN == 64) ? 11 : 8;
    localparam int MAN_W = FLEN - 1 - EXP_W;

    localparam logic [4:0] FPU_OP_SGNJ  = 5'd6;
    localparam logic [4:0] FPU_OP_SGNJN = 5'd7;
    localparam logic [4:0] FPU_OP_SGNJX = 5'd8;
    localparam logic [4:0] FPU_OP_MIN   = 5'd9;
    localparam logic [4:0] FPU_OP_MAX   = 5'd10;

    localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic             a_sign, b_sign;
    logic [FLEN-2:0]  a_mag, b_mag;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_nan, b_nan, a_snan, b_snan;
    logic             a_lt_b;
    logic             supported;
    logic [FLEN-1:0]  res_data;
    logic             res_inv;

    logic [FLEN:0]    ent0, ent1;
    logic [1:0]       count;
    logic             push, pop;

    assign a_sign = a[FLEN-1];
    assign b_sign = b[FLEN-1];
    assign a_mag  = a[FLEN-2:0];
    assign b_mag  = b[FLEN-2:0];
    assign a_exp  = a[FLEN-2 -: EXP_W];
    assign b_exp  = b[FLEN-2 -: EXP_W];
    assign a_man  = a[MAN_W-1:0];
    assign b_man  = b[MAN_W-1:0];

    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];

    assign supported = (op == FPU_OP_SGNJ) || (op == FPU_OP_SGNJN) || (op == FPU_OP_SGNJX) ||
                       (op == FPU_OP_MIN)  || (op == FPU_OP_MAX);

    // Sign-magnitude ordering: differing signs put the negative one first (so -0 < +0).
    always_comb begin
        a_lt_b = 1'b0;
        if (a_sign != b_sign)
            a_lt_b = a_sign;
        else if (!a_sign)
            a_lt_b = (a_mag < b_mag);
        else
            a_lt_b = (a_mag > b_mag);
    end

    always_comb begin
        res_data = '0;
        res_inv  = 1'b0;
        case (op)
            FPU_OP_SGNJ:  res_data = {b_sign, a_mag};
            FPU_OP_SGNJN: res_data = {~b_sign, a_mag};
            FPU_OP_SGNJX: res_data = {a_sign ^ b_sign, a_mag};
            FPU_OP_MIN, FPU_OP_MAX: begin
                res_inv = a_snan || b_snan;
                if (a_nan && b_nan)
                    res_data = CANON_NAN;
                else if (a_nan)
                    res_data = b;
                else if (b_nan)
                    res_data = a;
                else if (op == FPU_OP_MIN)
                    res_data = a_lt_b ? a : b;
                else
                    res_data = a_lt_b ? b : a;
            end
            default: begin
                res_data = '0;
                res_inv  = 1'b0;
            end
        endcase
    end

    assign ready_out = (count < 2'd2) && supported;
    assign valid_out = (count != 2'd0);
    assign push      = valid_in && ready_out && !reset;
    assign pop       = valid_out && ready_in;

    // ent0 is always the head; a pop shifts ent1 forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        ent0 <= {res_inv, res_data};
                    else
                        ent1 <= {res_inv, res_data};
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    ent0 <= {res_inv, res_data};
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    assign float_out = valid_out ? ent0[FLEN-1:0] : '0;
    assign invalid   = valid_out ? ent0[FLEN] : 1'b0;

endmodule

// File: tb/tb_sign_minmax_unit.sv
// tb/tb_sign_minmax_unit.sv - randomized and directed bench for sign_minmax_unit (binary32 and binary64)
module tb_sign_minmax_unit;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SGNJ  = 5'd6;
    localparam logic [4:0] OP_SGNJN = 5'd7;
    localparam logic [4:0] OP_SGNJX = 5'd8;
    localparam logic [4:0] OP_MIN   = 5'd9;
    localparam logic [4:0] OP_MAX   = 5'd10;

    logic        clk, reset;
    logic        valid_in32, ready_out32, valid_out32, ready_in32, invalid32;
    logic [4:0]  op32;
    logic [31:0] a32, b32, float_out32;
    logic        valid_in64, ready_out64, valid_out64, ready_in64, invalid64;
    logic [4:0]  op64;
    logic [63:0] a64, b64, float_out64;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] q32[$];
    logic [64:0] q64[$];

    sign_minmax_unit #(.FLEN(32)) dut32 (
        .clk(clk), .reset(reset), .valid_in(valid_in32), .ready_out(ready_out32),
        .valid_out(valid_out32), .ready_in(ready_in32), .op(op32), .a(a32), .b(b32),
        .float_out(float_out32), .invalid(invalid32)
    );

    sign_minmax_unit #(.FLEN(64)) dut64 (
        .clk(clk), .reset(reset), .valid_in(valid_in64), .ready_out(ready_out64),
        .valid_out(valid_out64), .ready_in(ready_in64), .op(op64), .a(a64), .b(b64),
        .float_out(float_out64), .invalid(invalid64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_supported(input logic [4:0] o);
        return o == OP_SGNJ || o == OP_SGNJN || o == OP_SGNJX || o == OP_MIN || o == OP_MAX;
    endfunction

    function automatic bit is_nan(input bit w, input logic [63:0] x);
        if (w) return (x[62:52] == 11'h7FF) && (x[51:0] != 0);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit is_snan(input bit w, input logic [63:0] x);
        if (w) return is_nan(w, x) && !x[51];
        return is_nan(w, x) && !x[22];
    endfunction

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Numeric value of a non-NaN operand; binary32 infinities map beyond any finite binary32.
    function automatic real to_real(input bit w, input logic [63:0] x);
        real v;
        int  e;
        if (w) return $bitstoreal(x);
        e = int'(x[30:23]);
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = real'(x[22:0]) * pow2(-149);
        else             v = (real'(x[22:0]) + 8388608.0) * pow2(e - 150);
        return x[31] ? -v : v;
    endfunction

    function automatic logic [64:0] ref_result(input bit w, input logic [4:0] o,
                                               input logic [63:0] a, input logic [63:0] b);
        int          sb;
        logic [63:0] rest, canon;
        bit          sa, sbit, inv;
        real         va, vb;
        sb    = w ? 63 : 31;
        rest  = w ? (a & ~(64'd1 << 63)) : {33'd0, a[30:0]};
        sa    = a[sb];
        sbit  = b[sb];
        canon = w ? 64'h7FF8000000000000 : 64'h000000007FC00000;
        case (o)
            OP_SGNJ:  return {1'b0, rest | (64'(sbit) << sb)};
            OP_SGNJN: return {1'b0, rest | (64'(!sbit) << sb)};
            OP_SGNJX: return {1'b0, rest | (64'(sa ^ sbit) << sb)};
            default: begin
                inv = is_snan(w, a) || is_snan(w, b);
                if (is_nan(w, a) && is_nan(w, b)) return {inv, canon};
                if (is_nan(w, a)) return {inv, b};
                if (is_nan(w, b)) return {inv, a};
                va = to_real(w, a);
                vb = to_real(w, b);
                if (va < vb) return {inv, (o == OP_MIN) ? a : b};
                if (vb < va) return {inv, (o == OP_MIN) ? b : a};
                if (sa != sbit) begin
                    if (o == OP_MIN) return {inv, sa ? a : b};
                    return {inv, sa ? b : a};
                end
                return {inv, a};
            end
        endcase
    endfunction

    // One clock: check both DUTs against the queues, then apply the edge to the model.
    task automatic step();
        logic [64:0] e32, e64, n32, n64;
        bit          pu32, po32, pu64, po64;
        @(negedge clk);
        e32 = (q32.size() != 0) ? q32[0] : 65'd0;
        e64 = (q64.size() != 0) ? q64[0] : 65'd0;
        check("ready32", 64'(ready_out32), 64'((q32.size() < 2) && is_supported(op32)));
        check("valid32", 64'(valid_out32), 64'(q32.size() != 0));
        check("data32", 64'(float_out32), {32'd0, e32[31:0]});
        check("inv32", 64'(invalid32), 64'(e32[64]));
        check("ready64", 64'(ready_out64), 64'((q64.size() < 2) && is_supported(op64)));
        check("valid64", 64'(valid_out64), 64'(q64.size() != 0));
        check("data64", float_out64, e64[63:0]);
        check("inv64", 64'(invalid64), 64'(e64[64]));
        pu32 = valid_in32 && (q32.size() < 2) && is_supported(op32) && !reset;
        po32 = (q32.size() != 0) && ready_in32;
        pu64 = valid_in64 && (q64.size() < 2) && is_supported(op64) && !reset;
        po64 = (q64.size() != 0) && ready_in64;
        n32  = ref_result(1'b0, op32, {32'd0, a32}, {32'd0, b32});
        n64  = ref_result(1'b1, op64, a64, b64);
        @(posedge clk);
        if (reset) begin
            q32.delete();
            q64.delete();
        end else begin
            if (po32) void'(q32.pop_front());
            if (pu32) q32.push_back(n32);
            if (po64) void'(q64.pop_front());
            if (pu64) q64.push_back(n64);
        end
        #1;
    endtask

    task automatic drain();
        valid_in32 = 1'b0; valid_in64 = 1'b0;
        ready_in32 = 1'b1; ready_in64 = 1'b1;
        repeat (3) step();
    endtask

    task automatic dir32(input string tag, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input bit exp_inv);
        op32 = o; a32 = x; b32 = y; valid_in32 = 1'b1; ready_in32 = 1'b1;
        #1 check({tag, "_accept"}, 64'(ready_out32), 64'd1);
        step();
        valid_in32 = 1'b0; a32 = $urandom; b32 = $urandom;
        check({tag, "_valid"}, 64'(valid_out32), 64'd1);
        check({tag, "_data"}, 64'(float_out32), 64'(exp));
        check({tag, "_inv"}, 64'(invalid32), 64'(exp_inv));
        step();
    endtask

    task automatic dir64(input string tag, input logic [4:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp);
        op64 = o; a64 = x; b64 = y; valid_in64 = 1'b1; ready_in64 = 1'b1;
        step();
        valid_in64 = 1'b0;
        check({tag, "_valid"}, 64'(valid_out64), 64'd1);
        check({tag, "_data"}, float_out64, exp);
        step();
    endtask

    function automatic logic [63:0] pick_operand(input bit w);
        int r = $urandom_range(0, 11);
        logic [63:0] rnd = {$urandom, $urandom};
        if (w) begin
            case (r)
                0: return 64'h0000000000000000;
                1: return 64'h8000000000000000;
                2: return 64'h7FF8000000000000;
                3: return 64'h7FF0000000000001;
                4: return 64'h7FF0000000000000;
                5: return 64'hFFF0000000000000;
                6: return 64'hFFF8000000001234;
                default: return rnd;
            endcase
        end
        case (r)
            0: return 64'h00000000;
            1: return 64'h80000000;
            2: return 64'h7FC00000;
            3: return 64'h7F800001;
            4: return 64'h7F800000;
            5: return 64'hFF800000;
            6: return 64'hFFC01234;
            7: return {32'd0, 9'h000, rnd[22:0]};
            default: return {32'd0, rnd[31:0]};
        endcase
    endfunction

    function automatic logic [4:0] pick_op();
        int r = $urandom_range(0, 6);
        case (r)
            0: return OP_SGNJ;
            1: return OP_SGNJN;
            2: return OP_SGNJX;
            3: return OP_MIN;
            4: return OP_MAX;
            5: return OP_ADD;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        logic [63:0] t;
        reset = 1'b1;
        valid_in32 = 1'b0; ready_in32 = 1'b0; op32 = OP_SGNJ; a32 = '0; b32 = '0;
        valid_in64 = 1'b0; ready_in64 = 1'b0; op64 = OP_SGNJ; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_valid", 64'(valid_out32), 64'd0);
        check("rst_data", 64'(float_out32), 64'd0);
        check("rst_inv", 64'(invalid32), 64'd0);
        check("rst_ready", 64'(ready_out32), 64'd1);

        dir32("sgnjn", OP_SGNJN, 32'h3F800000, 32'h3F800000, 32'hBF800000, 1'b0);
        dir32("min_zero", OP_MIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
        dir32("max_zero", OP_MAX, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
        dir32("max_snan", OP_MAX, 32'h7F800001, 32'h40000000, 32'h40000000, 1'b1);
        dir32("min_qnan2", OP_MIN, 32'h7FC00000, 32'hFFC00000, 32'h7FC00000, 1'b0);
        dir64("sgnjx64", OP_SGNJX, 64'hC000000000000000, 64'h8000000000000000, 64'h4000000000000000);
        dir64("min_nan64", OP_MIN, 64'h7FF0000000000001, 64'hFFF8000000000000, 64'h7FF8000000000000);

        // Back-pressure: two accepted, third held until the first pop.
        ready_in32 = 1'b0; valid_in32 = 1'b1; op32 = OP_SGNJX;
        for (int i = 0; i < 3; i++) begin
            a32 = 32'h40000000 + 32'(i); b32 = 32'h80000000;
            #1 check($sformatf("bp_ready%0d", i), 64'(ready_out32), (i < 2) ? 64'd1 : 64'd0);
            if (i < 2) step();
        end
        ready_in32 = 1'b1;
        check("bp_head", 64'(float_out32), 64'hC0000000);
        step();
        check("bp_ready_after_pop", 64'(ready_out32), 64'd1);
        check("bp_head2", 64'(float_out32), 64'hC0000001);
        step();
        valid_in32 = 1'b0;
        check("bp_head3", 64'(float_out32), 64'hC0000002);
        drain();

        op32 = OP_ADD; valid_in32 = 1'b1;
        #1 check("unsup_ready", 64'(ready_out32), 64'd0);
        step();
        valid_in32 = 1'b0; op32 = OP_MIN;
        check("unsup_nopush", 64'(valid_out32), 64'd0);

        ready_in32 = 1'b0; valid_in32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000;
        repeat (2) step();
        check("full_count2", 64'(ready_out32), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0; valid_in32 = 1'b0;
        check("rst_mid_valid", 64'(valid_out32), 64'd0);
        check("rst_mid_data", 64'(float_out32), 64'd0);
        drain();

        for (int i = 0; i < 600; i++) begin
            valid_in32 = ($urandom_range(0, 3) != 0);
            ready_in32 = ($urandom_range(0, 9) < 7);
            op32 = pick_op();
            t = pick_operand(1'b0); a32 = t[31:0];
            t = pick_operand(1'b0); b32 = t[31:0];
            valid_in64 = ($urandom_range(0, 3) != 0);
            ready_in64 = ($urandom_range(0, 9) < 7);
            op64 = pick_op();
            a64 = pick_operand(1'b1);
            b64 = pick_operand(1'b1);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
